// File: rtl/branch_predictor_bht_if.sv
// Fetch/resolve bus between the core pipeline and the branch history table.
// The pipeline drives the fetch and ALU-resolution fields; the predictor drives the rest.
interface branch_predictor_bht_if #(
   parameter int ADDR_W = 22,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] i_IMEM_address;
   logic              i_IMEM_isbranch;
   logic [ADDR_W-1:0] i_ALU_pc;
   logic              i_ALU_isbranch;
   logic              i_ALU_outcome;
   logic              i_ALU_prediction;
   logic              o_taken;
   logic              o_valid;
   logic              o_flush;
   logic [CNT_W-1:0]  o_mispredicts;

   modport master (
      output i_IMEM_address, i_IMEM_isbranch, i_ALU_pc, i_ALU_isbranch,
             i_ALU_outcome, i_ALU_prediction,
      input  o_taken, o_valid, o_flush, o_mispredicts
   );

   modport slave (
      input  i_IMEM_address, i_IMEM_isbranch, i_ALU_pc, i_ALU_isbranch,
             i_ALU_outcome, i_ALU_prediction,
      output o_taken, o_valid, o_flush, o_mispredicts
   );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters; bimodal when GHR_W = 0, gshare otherwise.
// Lookup is combinational; training and history shift happen only at ALU resolution.
module branch_predictor_bht #(
   parameter int ADDR_W = 22,
   parameter int IDX_W  = 6,
   parameter int CTR_W  = 2,
   parameter int GHR_W  = 0,
   parameter int CNT_W  = 16
) (
   input logic                  i_Clk,
   input logic                  i_Reset_n,
   branch_predictor_bht_if.slave bus
);
   localparam int               DEPTH   = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

   logic [CTR_W-1:0] ctr [DEPTH];
   logic [IDX_W-1:0] ghr_ext;
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [CNT_W-1:0] mis_cnt;
   logic             upd;

   // Upper PC bits never reach the index; fold them into a sink so they read as used.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.i_IMEM_address, bus.i_ALU_pc};

   generate
      if (GHR_W == 0) begin : g_bimodal
         assign ghr_ext = '0;
      end else begin : g_gshare
         logic [GHR_W-1:0] ghr;
         assign ghr_ext = IDX_W'(ghr);
         if (GHR_W == 1) begin : g_h1
            always_ff @(posedge i_Clk or negedge i_Reset_n)
               if (!i_Reset_n)  ghr <= '0;
               else if (upd)    ghr <= bus.i_ALU_outcome;
         end else begin : g_hn
            always_ff @(posedge i_Clk or negedge i_Reset_n)
               if (!i_Reset_n)  ghr <= '0;
               else if (upd)    ghr <= {ghr[GHR_W-2:0], bus.i_ALU_outcome};
         end
      end
   endgenerate

   assign upd       = bus.i_ALU_isbranch;
   assign fetch_idx = bus.i_IMEM_address[IDX_W-1:0] ^ ghr_ext;
   assign upd_idx   = bus.i_ALU_pc[IDX_W-1:0] ^ ghr_ext;

   // No bypass: a same-cycle update to the fetched entry is seen only after the edge.
   assign bus.o_valid       = bus.i_IMEM_isbranch;
   assign bus.o_taken       = bus.i_IMEM_isbranch & ctr[fetch_idx][CTR_W-1];
   assign bus.o_flush       = bus.i_ALU_isbranch & (bus.i_ALU_outcome ^ bus.i_ALU_prediction);
   assign bus.o_mispredicts = mis_cnt;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_RST;
      end else if (upd) begin
         if (bus.i_ALU_outcome) begin
            if (ctr[upd_idx] != '1) ctr[upd_idx] <= ctr[upd_idx] + 1'b1;
         end else begin
            if (ctr[upd_idx] != '0) ctr[upd_idx] <= ctr[upd_idx] - 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n)                         mis_cnt <= '0;
      else if (bus.o_flush && mis_cnt != '1)  mis_cnt <= mis_cnt + 1'b1;
   end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed checks of a bimodal instance (defaults) and a 4-bit gshare instance with a 2-bit miss counter.
module tb_branch_predictor_bht;
   logic clk;
   logic rst_a_n, rst_b_n;
   int   checks = 0;
   int   failures = 0;

   branch_predictor_bht_if #(.ADDR_W(22), .CNT_W(16)) bus_a ();
   branch_predictor_bht_if #(.ADDR_W(22), .CNT_W(2))  bus_b ();

   branch_predictor_bht u_bim (.i_Clk(clk), .i_Reset_n(rst_a_n), .bus(bus_a));
   branch_predictor_bht #(.GHR_W(4), .CNT_W(2)) u_gsh (.i_Clk(clk), .i_Reset_n(rst_b_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [21:0] fpc, input logic fbr, input logic [21:0] apc,
                        input logic abr, input logic out, input logic pred);
      bus_a.i_IMEM_address = fpc;  bus_a.i_IMEM_isbranch = fbr;
      bus_a.i_ALU_pc = apc;        bus_a.i_ALU_isbranch = abr;
      bus_a.i_ALU_outcome = out;   bus_a.i_ALU_prediction = pred;
   endtask

   task automatic set_b(input logic [21:0] fpc, input logic fbr, input logic [21:0] apc,
                        input logic abr, input logic out, input logic pred);
      bus_b.i_IMEM_address = fpc;  bus_b.i_IMEM_isbranch = fbr;
      bus_b.i_ALU_pc = apc;        bus_b.i_ALU_isbranch = abr;
      bus_b.i_ALU_outcome = out;   bus_b.i_ALU_prediction = pred;
   endtask

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      #3;

      // ---------------- bimodal instance ----------------
      chk("a_rst_mis", bus_a.o_mispredicts, 0);
      set_a(22'h10, 1, 0, 0, 0, 0); #1;
      chk("a_rst_valid", bus_a.o_valid, 1);
      chk("a_rst_taken", bus_a.o_taken, 0);
      set_a(22'h10, 0, 0, 0, 0, 0); #1;
      chk("a_nobr_valid", bus_a.o_valid, 0);
      chk("a_nobr_taken", bus_a.o_taken, 0);
      @(negedge clk) rst_a_n = 1'b1;
      tick();

      // two taken mispredicts: 01 -> 10 -> 11
      set_a(22'h10, 1, 22'h10, 1, 1, 0); #1;
      chk("a_flush1", bus_a.o_flush, 1);
      chk("a_nobypass_taken", bus_a.o_taken, 0);
      tick();
      chk("a_mis1", bus_a.o_mispredicts, 1);
      chk("a_after1_taken", bus_a.o_taken, 1);
      tick();
      chk("a_mis2", bus_a.o_mispredicts, 2);
      set_a(22'h10, 1, 0, 0, 0, 0); #1;
      chk("a_ctr11_taken", bus_a.o_taken, 1);
      chk("a_noflush", bus_a.o_flush, 0);
      set_a(22'h50, 1, 0, 0, 0, 0); #1;
      chk("a_alias_taken", bus_a.o_taken, 1);
      set_a(22'h11, 1, 0, 0, 0, 0); #1;
      chk("a_other_taken", bus_a.o_taken, 0);

      // saturate at 11, then a not-taken mispredict leaves 10
      set_a(0, 0, 22'h10, 1, 1, 1); #1;
      chk("a_correct_noflush", bus_a.o_flush, 0);
      tick(); tick();
      chk("a_mis_hold", bus_a.o_mispredicts, 2);
      set_a(0, 0, 22'h10, 1, 0, 1); #1;
      chk("a_flush_nt", bus_a.o_flush, 1);
      tick();
      chk("a_mis3", bus_a.o_mispredicts, 3);
      set_a(22'h10, 1, 0, 0, 0, 0); #1;
      chk("a_ctr10_taken", bus_a.o_taken, 1);
      set_a(0, 0, 22'h10, 1, 0, 0); tick();
      set_a(22'h10, 1, 0, 0, 0, 0); #1;
      chk("a_ctr01_taken", bus_a.o_taken, 0);
      chk("a_mis3_hold", bus_a.o_mispredicts, 3);

      // same-cycle fetch and update of one entry
      set_a(22'h20, 1, 22'h20, 1, 1, 1); #1;
      chk("a_same_cyc_taken", bus_a.o_taken, 0);
      tick();
      set_a(22'h20, 1, 0, 0, 0, 0); #1;
      chk("a_next_cyc_taken", bus_a.o_taken, 1);

      // X on ALU fields while not a branch
      bus_a.i_ALU_isbranch = 1'b0;
      bus_a.i_ALU_pc = 'x; bus_a.i_ALU_outcome = 1'bx; bus_a.i_ALU_prediction = 1'bx;
      #1;
      chk("a_x_noflush", bus_a.o_flush, 0);
      tick(); tick();
      chk("a_x_mis", bus_a.o_mispredicts, 3);
      chk("a_x_taken20", bus_a.o_taken, 1);
      bus_a.i_IMEM_address = 22'h10; #1;
      chk("a_x_taken10", bus_a.o_taken, 0);
      bus_a.i_IMEM_isbranch = 1'b0; bus_a.i_IMEM_address = 22'h20; #1;
      chk("a_nobr_trained", bus_a.o_taken, 0);
      set_a(0, 0, 0, 0, 0, 0);

      // ---------------- gshare instance ----------------
      @(negedge clk) rst_b_n = 1'b1;
      tick();
      // outcomes 1,1,0,1 at pc 0, all mispredicted: indices 0,1,3,6 trained
      set_b(0, 0, 0, 1, 1, 0); #1;
      chk("b_flush1", bus_b.o_flush, 1);
      tick(); chk("b_mis1", bus_b.o_mispredicts, 1);
      set_b(0, 0, 0, 1, 1, 0); tick(); chk("b_mis2", bus_b.o_mispredicts, 2);
      set_b(0, 0, 0, 1, 0, 1); tick(); chk("b_mis3", bus_b.o_mispredicts, 3);
      set_b(0, 0, 0, 1, 1, 0); tick(); chk("b_mis_sat", bus_b.o_mispredicts, 3);

      // history now 1101: fetch index = pc ^ 0xD
      set_b(22'h0D, 1, 0, 0, 0, 0); #1; chk("b_f0D_idx0", bus_b.o_taken, 1);
      set_b(22'h0C, 1, 0, 0, 0, 0); #1; chk("b_f0C_idx1", bus_b.o_taken, 1);
      set_b(22'h0E, 1, 0, 0, 0, 0); #1; chk("b_f0E_idx3", bus_b.o_taken, 0);
      set_b(22'h00, 1, 0, 0, 0, 0); #1; chk("b_f00_idxD", bus_b.o_taken, 0);

      // update pc 0 hits index 0xD; history becomes 1011
      set_b(22'h06, 1, 0, 1, 1, 1); #1;
      chk("b_f06_idxB", bus_b.o_taken, 0);
      chk("b_upd_noflush", bus_b.o_flush, 0);
      tick();
      set_b(22'h06, 1, 0, 0, 0, 0); #1;
      chk("b_f06_idxD", bus_b.o_taken, 1);
      chk("b_mis_sat_hold", bus_b.o_mispredicts, 3);

      // mid-cycle reset discards everything at once
      #2 rst_b_n = 1'b0;
      #1;
      chk("b_rst_mis", bus_b.o_mispredicts, 0);
      chk("b_rst_f06", bus_b.o_taken, 0);
      set_b(22'h00, 1, 0, 1, 1, 0); #1;
      chk("b_rst_f00", bus_b.o_taken, 0);
      chk("b_rst_flush", bus_b.o_flush, 1);
      tick();
      chk("b_rst_noupd_mis", bus_b.o_mispredicts, 0);
      chk("b_rst_noupd_f00", bus_b.o_taken, 0);
      set_b(0, 0, 0, 0, 0, 0);
      @(negedge clk) rst_b_n = 1'b1;
      tick();
      set_b(22'h01, 1, 0, 0, 0, 0); #1;
      chk("b_post_rst_f01", bus_b.o_taken, 0);
      set_b(22'h0D, 1, 0, 0, 0, 0); #1;
      chk("b_post_rst_f0D", bus_b.o_taken, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
